// File: rtl/npu_pkg.sv
// Shared NPU definitions: MAC sequencer FSM states and MAC accumulator geometry.
package npu_pkg;

    localparam int unsigned MAC_ACC_WIDTH = 36;
    localparam int unsigned MAC_OUT_LSB   = 20;
    localparam int unsigned PERF_CNT_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ACC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } mac_seq_state_e;

endpackage

// File: rtl/mac_seq.sv
// mac_seq: operand sequencer and result collector for one MAC lane.
// Loads the bias, streams operand beats into the MAC, drains the truncated
// accumulator and returns it over a valid/ready result port.
// Optional feature macro: MAC_SEQ_PERF_EN (done/stall performance counters).
module mac_seq #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [LEN_W-1:0]      cmd_len_i,
    input  logic [DATA_WIDTH-1:0] cmd_bias_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic [DATA_WIDTH-1:0] op_a_i,
    input  logic [DATA_WIDTH-1:0] op_b_i,
    output logic [DATA_WIDTH-1:0] mac_rs1_o,
    output logic [DATA_WIDTH-1:0] mac_rs2_o,
    output logic                  mac_func_o,
    output logic                  mac_activated_o,
    input  logic [DATA_WIDTH-1:0] mac_vrd_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [DATA_WIDTH-1:0] res_data_o,
    output logic [31:0]           done_cnt_o,
    output logic [31:0]           stall_cnt_o
);
    import npu_pkg::*;

    mac_seq_state_e        state_q, state_d;
    logic [LEN_W-1:0]      remain_q, remain_d;
    logic [DATA_WIDTH-1:0] bias_q, bias_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;

    // Next-state, datapath updates and MAC/handshake drive per state
    always_comb begin
        state_d         = state_q;
        remain_d        = remain_q;
        bias_d          = bias_q;
        res_data_d      = res_data_q;
        cmd_ready_o     = 1'b0;
        op_ready_o      = 1'b0;
        res_valid_o     = 1'b0;
        mac_rs1_o       = '0;
        mac_rs2_o       = '0;
        mac_func_o      = 1'b0;
        mac_activated_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    remain_d = cmd_len_i;
                    bias_d   = cmd_bias_i;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mac_func_o      = 1'b1;
                mac_activated_o = 1'b1;
                mac_rs2_o       = bias_q;
                state_d         = (remain_q != '0) ? ST_ACC : ST_DRAIN;
            end
            ST_ACC: begin
                op_ready_o      = 1'b1;
                mac_rs1_o       = op_a_i;
                mac_rs2_o       = op_b_i;
                mac_activated_o = op_valid_i;
                if (op_valid_i) begin
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // MAC inputs are idle here, so vrd shows accumulator[35:20]
                res_data_d = mac_vrd_i;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            remain_q   <= '0;
            bias_q     <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            bias_q     <= bias_d;
            res_data_q <= res_data_d;
        end
    end

    assign res_data_o = res_data_q;

`ifdef MAC_SEQ_PERF_EN
    logic [PERF_CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Completed-command and ACC-stall counters, free-running with wrap
    always_comb begin
        done_cnt_d  = done_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_RESP && res_ready_i) begin
            done_cnt_d = done_cnt_q + PERF_CNT_W'(1);
        end
        if (state_q == ST_ACC && !op_valid_i) begin
            stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            done_cnt_q  <= done_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign done_cnt_o  = done_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign done_cnt_o  = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq with a behavioural MAC lane attached.
module tb_mac_seq;
    import npu_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned LW    = 8;
    localparam int unsigned MAXB  = 64;
`ifdef MAC_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [LW-1:0] cmd_len_i;
    logic [DW-1:0] cmd_bias_i;
    logic          op_valid_i;
    logic          op_ready_o;
    logic [DW-1:0] op_a_i;
    logic [DW-1:0] op_b_i;
    logic [DW-1:0] mac_rs1;
    logic [DW-1:0] mac_rs2;
    logic          mac_func;
    logic          mac_act;
    logic [DW-1:0] mac_vrd;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [DW-1:0] res_data_o;
    logic [31:0]   done_cnt_o;
    logic [31:0]   stall_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] beat_a [MAXB];
    logic [DW-1:0] beat_b [MAXB];
    int            stall_before [MAXB];

    mac_seq #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_len_i       (cmd_len_i),
        .cmd_bias_i      (cmd_bias_i),
        .op_valid_i      (op_valid_i),
        .op_ready_o      (op_ready_o),
        .op_a_i          (op_a_i),
        .op_b_i          (op_b_i),
        .mac_rs1_o       (mac_rs1),
        .mac_rs2_o       (mac_rs2),
        .mac_func_o      (mac_func),
        .mac_activated_o (mac_act),
        .mac_vrd_i       (mac_vrd),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready_i),
        .res_data_o      (res_data_o),
        .done_cnt_o      (done_cnt_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    // Behavioural MAC lane: 36-bit accumulator, load or multiply-accumulate
    logic [MAC_ACC_WIDTH-1:0] mac_acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_acc <= '0;
        end else if (mac_act) begin
            if (mac_func) mac_acc <= MAC_ACC_WIDTH'(mac_rs2);
            else          mac_acc <= mac_acc + MAC_ACC_WIDTH'(mac_rs1) * MAC_ACC_WIDTH'(mac_rs2);
        end
    end
    assign mac_vrd = mac_acc[MAC_OUT_LSB +: DW];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Dot product from the arithmetic rules: zero-extended bias plus products, mod 2^36
    function automatic logic [DW-1:0] ref_dot(input int len, input logic [DW-1:0] bias);
        logic [MAC_ACC_WIDTH-1:0] acc;
        acc = MAC_ACC_WIDTH'(bias);
        for (int i = 0; i < len; i++) begin
            acc = acc + MAC_ACC_WIDTH'(beat_a[i]) * MAC_ACC_WIDTH'(beat_b[i]);
        end
        return acc[MAC_OUT_LSB +: DW];
    endfunction

    // One full command: handshake, beats with stalls, result with hold-off, return to IDLE
    task automatic run_cmd(input string name, input int len, input logic [DW-1:0] bias,
                           input int hold, input logic [DW-1:0] exp_res,
                           input int exp_lat, input int exp_stalls);
        int          cyc;
        int          beat;
        int          stall_left;
        int          acc_cycles;
        logic        hs;
        logic        stable;
        logic [DW-1:0] held;
        logic [31:0] stall0;
        logic [31:0] done0;
        stall0 = stall_cnt_o;
        chk({name, " cmd_ready idle"}, 64'(cmd_ready_o), 64'(1));
        cmd_valid_i = 1'b1;
        cmd_len_i   = LW'(len);
        cmd_bias_i  = bias;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        cmd_len_i   = LW'($urandom);
        cmd_bias_i  = DW'($urandom);
        cyc = 1;
        chk({name, " load drive"}, 64'({mac_func, mac_act, mac_rs1, mac_rs2}),
            64'({1'b1, 1'b1, 16'h0000, bias}));
        beat       = 0;
        stall_left = (len > 0) ? stall_before[0] : 0;
        acc_cycles = 0;
        while (!res_valid_o && cyc < 4000) begin
            if (op_ready_o) begin
                acc_cycles++;
                if (stall_left > 0) begin
                    op_valid_i = 1'b0;
                    op_a_i     = DW'($urandom);
                    op_b_i     = DW'($urandom);
                    stall_left--;
                end else begin
                    op_valid_i = 1'b1;
                    op_a_i     = beat_a[beat % MAXB];
                    op_b_i     = beat_b[beat % MAXB];
                end
            end else begin
                op_valid_i = 1'b0;
            end
            hs = op_ready_o && op_valid_i;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                beat++;
                if (beat < len && beat < MAXB) stall_left = stall_before[beat];
            end
        end
        op_valid_i = 1'b0;
        chk({name, " res_valid"}, 64'(res_valid_o), 64'(1));
        chk({name, " latency"}, 64'(cyc), 64'(exp_lat));
        chk({name, " res_data"}, 64'(res_data_o), 64'(exp_res));
        chk({name, " acc cycles"}, 64'(acc_cycles), 64'(len + exp_stalls));
        chk({name, " stall_cnt delta"}, 64'(stall_cnt_o - stall0), PERF ? 64'(exp_stalls) : 64'(0));
        held   = res_data_o;
        stable = 1'b1;
        res_ready_i = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (res_data_o !== held || res_valid_o !== 1'b1 || cmd_ready_o !== 1'b0) stable = 1'b0;
        end
        chk({name, " hold stable"}, 64'(stable), 64'(1));
        done0 = done_cnt_o;
        res_ready_i = 1'b1;
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        chk({name, " idle after resp"}, 64'({cmd_ready_o, res_valid_o}), 64'(2'b10));
        chk({name, " done_cnt delta"}, 64'(done_cnt_o - done0), PERF ? 64'(1) : 64'(0));
    endtask

    typedef struct {
        string         name;
        int            len;
        logic [DW-1:0] bias;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            stall_pos;
        int            stall_n;
        int            hold;
        logic [DW-1:0] exp_res;
        int            exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{"basic",      3, 16'h0000, 16'h4000, 16'h4000, 0, 0, 0, 16'h0300, 6};
        vecs[1] = '{"stall",      3, 16'h0000, 16'h4000, 16'h4000, 1, 2, 0, 16'h0300, 8};
        vecs[2] = '{"zero_len",   0, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 3};
        vecs[3] = '{"wrap16",    16, 16'h0000, 16'hFFFF, 16'hFFFF, 0, 0, 0, 16'hFFFE, 19};
        vecs[4] = '{"wrap17",    17, 16'h0000, 16'hFFFF, 16'hFFFF, 0, 0, 0, 16'h0FFD, 20};
        vecs[5] = '{"backpress",  3, 16'h0000, 16'h4000, 16'h4000, 0, 0, 5, 16'h0300, 6};
        vecs[6] = '{"bias_low",   1, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000, 4};
        vecs[7] = '{"two_beats",  2, 16'h0000, 16'h8000, 16'h8000, 0, 1, 2, 16'h0800, 6};

        rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_len_i = '0; cmd_bias_i = '0;
        op_valid_i = 1'b0; op_a_i = '0; op_b_i = '0; res_ready_i = 1'b0;
        #12;
        chk("reset cmd_ready", 64'(cmd_ready_o), 64'(1));
        chk("reset outputs", 64'({op_ready_o, res_valid_o, mac_func, mac_act, mac_rs1, mac_rs2}), 64'(0));
        chk("reset res_data", 64'(res_data_o), 64'(0));
        chk("reset counters", 64'({done_cnt_o, stall_cnt_o}), 64'(0));
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < MAXB; i++) begin
                beat_a[i] = vecs[v].a;
                beat_b[i] = vecs[v].b;
                stall_before[i] = 0;
            end
            stall_before[vecs[v].stall_pos] = vecs[v].stall_n;
            run_cmd(vecs[v].name, vecs[v].len, vecs[v].bias, vecs[v].hold,
                    vecs[v].exp_res, vecs[v].exp_lat, vecs[v].stall_n);
        end

        // Randomized commands against the dot-product model
        for (int r = 0; r < 24; r++) begin
            int len;
            int stalls;
            logic [DW-1:0] bias;
            len    = int'($urandom_range(0, 12));
            bias   = DW'($urandom);
            stalls = 0;
            for (int i = 0; i < MAXB; i++) begin
                beat_a[i] = DW'($urandom);
                beat_b[i] = DW'($urandom);
                stall_before[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                if (i < len) stalls += stall_before[i];
            end
            run_cmd($sformatf("rand%0d", r), len, bias, int'($urandom_range(0, 3)),
                    ref_dot(len, bias), len + 3 + stalls, stalls);
        end

        // Reset in the middle of a K=4 accumulation, after the first beat
        for (int i = 0; i < MAXB; i++) begin
            beat_a[i] = 16'h4000; beat_b[i] = 16'h4000; stall_before[i] = 0;
        end
        cmd_valid_i = 1'b1; cmd_len_i = LW'(4); cmd_bias_i = 16'h0000;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(posedge clk); #1;
        op_valid_i = 1'b1; op_a_i = 16'h4000; op_b_i = 16'h4000;
        @(posedge clk); #1;
        chk("pre-reset in acc", 64'(op_ready_o), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset cmd_ready", 64'(cmd_ready_o), 64'(1));
        chk("mid reset outputs", 64'({op_ready_o, res_valid_o, mac_func, mac_act, mac_rs1, mac_rs2}), 64'(0));
        chk("mid reset res/cnt", 64'({res_data_o, done_cnt_o[15:0], stall_cnt_o[15:0]}), 64'(0));
        op_valid_i = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_cmd("after_reset", 1, 16'h0000, 0, 16'h0100, 4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_seq.md
# mac_seq

Operand sequencer and result collector for one MAC lane. It accepts a dot-product command (length plus bias), then streams operand pairs into the MAC's `rs1`/`rs2`/`func`/`activated` inputs. It drains the accumulator through the MAC's truncated `vrd` output and returns the 16-bit result over a valid/ready port. It sits between the NPU operand buffers and each MAC instance, and is the initiator side of the MAC's operand/control interface.

## Interface
- `DATA_WIDTH`, 16: operand and result width; must match the MAC.
- `LEN_W`, 8: width of the command length field, giving a maximum of 2^LEN_W−1 beats.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: command accepted when high together with `cmd_valid_i`.
- `cmd_len_i` in LEN_W: number of operand beats to accumulate.
- `cmd_bias_i` in DATA_WIDTH: value loaded into the accumulator before accumulation.
- `op_valid_i` in 1: operand pair valid.
- `op_ready_o` out 1: operand pair consumed.
- `op_a_i`, `op_b_i` in DATA_WIDTH: operand pair.
- `mac_rs1_o`, `mac_rs2_o` out DATA_WIDTH: MAC operand inputs.
- `mac_func_o` out 1: MAC function select; 1 = load `rs2`, 0 = multiply-accumulate.
- `mac_activated_o` out 1: MAC accumulator write enable.
- `mac_vrd_i` in DATA_WIDTH: MAC output (accumulator bits [35:20], combinational).
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: result accepted when high together with `res_valid_o`.
- `res_data_o` out DATA_WIDTH: registered result.
- `done_cnt_o` out 32: completed commands (see Configuration).
- `stall_cnt_o` out 32: accumulate-state stall cycles (see Configuration).

## Operation
The FSM has five states:
- **IDLE**
  - `cmd_ready_o`=1.
  - On a command handshake: latch `cmd_len_i` into `remain` and `cmd_bias_i` into `bias_q`, then go to LOAD.
- **LOAD** (one cycle)
  - Drive `mac_func_o`=1, `mac_activated_o`=1, `mac_rs2_o`=`bias_q`, `mac_rs1_o`=0.
  - Next state is ACC if `remain`≠0, otherwise DRAIN.
- **ACC**
  - Drive `op_ready_o`=1, `mac_func_o`=0.
  - Pass `mac_rs1_o`=`op_a_i` and `mac_rs2_o`=`op_b_i` through combinationally.
  - Drive `mac_activated_o`=`op_valid_i`.
  - Each handshake decrements `remain`; the handshake taking `remain` to 0 moves the FSM to DRAIN.
  - A cycle with `op_valid_i`=0 is a stall; state is held and the MAC does not update.
- **DRAIN** (one cycle)
  - Drive `mac_rs1_o`=`mac_rs2_o`=0, `mac_func_o`=0, `mac_activated_o`=0, so `mac_vrd_i` equals accumulator[35:20].
  - Register `mac_vrd_i` into `res_data_o`, then go to RESP.
- **RESP**
  - `res_valid_o`=1.
  - `res_data_o` holds stable until the handshake, then the FSM returns to IDLE.

Outside LOAD and ACC, all `mac_*` outputs are 0. `op_ready_o` is high only in ACC, and `cmd_ready_o` only in IDLE.

Arithmetic belongs to the MAC:
- The 36-bit accumulator wraps modulo 2^36.
- The bias is zero-extended into the accumulator's low bits, so a bias below 2^20 is invisible in the result.
- The sequencer performs no rounding and no saturation.

## Timing
- Reset values: state IDLE; `cmd_ready_o`=1 (combinational from IDLE); every other output 0; `res_data_o`=0; counters 0.
- With no stalls, a command handshake in cycle 0 is followed by:
  - LOAD in cycle 1,
  - ACC in cycles 2..K+1,
  - DRAIN in cycle K+2,
  - `res_valid_o` high from cycle K+3.
- K=0: LOAD → DRAIN, with `res_valid_o` from cycle 3.
- Each stall cycle adds one cycle of latency.
- Back-to-back commands: the next `cmd_ready_o` rises the cycle after the result handshake.
- Reset asserted mid-command: the FSM returns to IDLE immediately. The command is dropped and any operand beat in flight is not consumed. The MAC shares `rst_n`, so its accumulator clears as well.

## Configuration
- `MAC_SEQ_PERF_EN` defined:
  - `done_cnt_o` increments on every result handshake.
  - `stall_cnt_o` increments on every ACC cycle with `op_valid_i`=0.
  - Both counters are 32-bit, wrap, and reset to 0.
- `MAC_SEQ_PERF_EN` undefined: both ports are tied to 0 and the counters are not built.

## Structure
- The shared package `npu_pkg` holds:
  - the state enum (IDLE, LOAD, ACC, DRAIN, RESP),
  - `MAC_ACC_WIDTH`=36,
  - `MAC_OUT_LSB`=20.
- No sub-module is needed; the perf counters are inline logic under the macro.
- The bench instantiates `mac_seq` together with the MAC.

## Test plan
- **Basic accumulate**
  - Stimulus: K=3, bias=0, three beats a=b=0x4000.
  - Required: `res_data_o`=0x0300, with `res_valid_o` in cycle 6 after the command handshake.
- **Stalls**
  - Stimulus: same beats, `op_valid_i` low for 2 cycles between beats 1 and 2.
  - Required: result 0x0300, `res_valid_o` 2 cycles later, `stall_cnt_o`=2.
- **Zero length**
  - Stimulus: K=0, bias=0x1234.
  - Required: no `op_ready_o` pulse, result 0x0000 in cycle 3.
- **Width and wrap**
  - Stimulus: 16 beats of a=b=0xFFFF, then a separate command with 17 beats.
  - Required: 16 beats give result 0xFFFE; 17 beats give 0x0FFD (36-bit wrap).
- **Backpressure**
  - Stimulus: `res_ready_i` low for 5 cycles.
  - Required: `res_data_o` stable and `cmd_ready_o`=0 throughout; IDLE the cycle after the handshake; `done_cnt_o` increments by 1.
- **Reset mid-ACC**
  - Stimulus: `rst_n` pulsed after beat 1 of K=4.
  - Required: all outputs 0, state IDLE; a following K=1 command with a=b=0x4000 gives 0x0100.
